ahbtoapb3_transfer_ctrl: RTL and testbench

//  AHB-Lite slave-side transfer controller of the AHB-to-APB3 bridge, directly upstream of the PENABLE scheduler.

---
 rtl/coreahbtoapb3_pkg.sv | 42 ++++
 rtl/ahbtoapb3_timeout_counter.sv | 34 +++
 rtl/ahbtoapb3_transfer_ctrl.sv | 148 ++++++++++++++
 tb/tb_ahbtoapb3_transfer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/coreahbtoapb3_pkg.sv
// Shared definitions for the AHB-to-APB3 bridge: FSM state encoding, AHB
// transfer/response codes and small state-decode helpers.
package coreahbtoapb3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic trans_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

  // States in which the slave is ready and a new address phase may be taken
  function automatic logic hready_for(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR2);
  endfunction

  function automatic logic hresp_for(input state_e s);
    return ((s == ST_ERR1) || (s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

endpackage

// File: rtl/ahbtoapb3_timeout_counter.sv
// Counts PENABLE-high cycles that are still waiting for PREADY; flags the last
// permitted cycle. A zero limit disables the flag.
module ahbtoapb3_timeout_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [15:0] limit_i,
  output logic        hit_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    if (clr_i) begin
      count_d = 16'd0;
    end else if (en_i) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = (limit_i != 16'd0) && (count_q == (limit_i - 16'd1));

endmodule

// File: rtl/ahbtoapb3_transfer_ctrl.sv
// AHB-Lite slave transfer controller of the AHB-to-APB3 bridge: registers AHB
// address phases onto APB and hands PENABLE timing to the downstream scheduler.
module ahbtoapb3_transfer_ctrl
  import coreahbtoapb3_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  PENABLE,
  output logic                  setPenable,
  output logic                  clrPenable
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  setpen_q, setpen_d;
  logic                  hreadyout_q, hresp_q;

  logic accept_s, access_s, cnt_hit_s, timeout_hit_s, complete_s;

  assign access_s      = (state_q == ST_ACCESS);
  assign accept_s      = HSEL & HREADY & trans_active(HTRANS);
  // PREADY always beats the timeout, so PSLVERR alone decides a late-ready response
  assign timeout_hit_s = cnt_hit_s & ~PREADY;
  assign complete_s    = access_s & PENABLE & (PREADY | timeout_hit_s);

  ahbtoapb3_timeout_counter u_timeout (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .en_i    (access_s & PENABLE & ~PREADY),
    .clr_i   (~access_s),
    .limit_i (TimeoutLimit),
    .hit_o   (cnt_hit_s)
  );

  always_comb begin
    state_d  = state_q;
    psel_d   = psel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    setpen_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept_s) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          if (HWRITE) begin
            state_d = ST_WDATA;
          end else begin
            state_d  = ST_SETUP;
            psel_d   = 1'b1;
            setpen_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        pwdata_d = HWDATA;
        state_d  = ST_SETUP;
        psel_d   = 1'b1;
        setpen_d = 1'b1;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (complete_s) begin
          if (!pwrite_q) begin
            hrdata_d = PRDATA;
          end else begin
            hrdata_d = hrdata_q;
          end
          psel_d  = 1'b0;
          state_d = (PSLVERR | timeout_hit_s) ? ST_ERR1 : ST_DONE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        psel_d  = 1'b0;
      end
    endcase
  end

  // AHB response flags are decoded from the next state so they stay registered
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      setpen_q    <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      setpen_q    <= setpen_d;
      hreadyout_q <= hready_for(state_d);
      hresp_q     <= hresp_for(state_d);
    end
  end

  assign HREADYOUT  = hreadyout_q;
  assign HRESP      = hresp_q;
  assign HRDATA     = hrdata_q;
  assign PSEL       = psel_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign setPenable = setpen_q;
  assign clrPenable = complete_s;

endmodule

// File: tb/tb_ahbtoapb3_transfer_ctrl.sv
// Bench for ahbtoapb3_transfer_ctrl with a behavioural PENABLE scheduler and
// APB slave; responses are checked by a scoreboard monitor.
module tb_ahbtoapb3_transfer_ctrl;
  import coreahbtoapb3_pkg::*;

  localparam int TO = 4;

  typedef struct {
    int          done_cyc;
    int          psel_cyc;
    logic        resp;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
  logic        PSEL, PWRITE, PREADY, PSLVERR, PENABLE, setPenable, clrPenable;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pen_cnt;
  logic        pen_dly;
  int          bfm_waits = 0;
  logic        bfm_err   = 1'b0;
  logic        bfm_stuck = 1'b0;
  logic [31:0] bfm_rdata = 32'd0;

  ahbtoapb3_transfer_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PENABLE(PENABLE), .setPenable(setPenable), .clrPenable(clrPenable)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  // PENABLE scheduler: rises two cycles after setPenable, drops on clrPenable
  always @(posedge HCLK) begin
    if (HRESET) begin
      pen_dly <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      pen_dly <= setPenable;
      if (clrPenable) PENABLE <= 1'b0;
      else if (pen_dly) PENABLE <= 1'b1;
    end
  end

  // APB slave: PREADY after bfm_waits PENABLE-high cycles
  always @(posedge HCLK) begin
    if (HRESET || !PENABLE) pen_cnt <= 0;
    else pen_cnt <= pen_cnt + 1;
  end
  assign PREADY  = PENABLE & ~bfm_stuck & (pen_cnt == bfm_waits);
  assign PSLVERR = bfm_err & PREADY;
  assign PRDATA  = bfm_rdata;
  assign HREADY  = HREADYOUT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic        prev_rdy, prev_resp, prev_psel;
    int          sp_cnt, cp_cnt, psel_cyc;
    logic [31:0] psel_wdata;
    prev_rdy = 1'b1; prev_resp = 1'b0; prev_psel = 1'b0;
    sp_cnt = 0; cp_cnt = 0; psel_cyc = -1; psel_wdata = 32'd0;
    forever begin
      @(posedge HCLK);
      #1;
      if (HRESET) begin
        prev_rdy = 1'b1; prev_resp = 1'b0; prev_psel = 1'b0;
        sp_cnt = 0; cp_cnt = 0; psel_cyc = -1;
      end else begin
        if (setPenable) sp_cnt++;
        if (clrPenable) cp_cnt++;
        if (PSEL && !prev_psel) begin
          psel_cyc   = cyc;
          psel_wdata = PWDATA;
        end
        if (HREADYOUT && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_response: HREADYOUT rose at cycle %0d with nothing expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("psel_cycle", psel_cyc, e.psel_cyc);
            check("hresp", {31'd0, HRESP}, {31'd0, e.resp});
            check("setPenable_count", sp_cnt, 32'd1);
            check("clrPenable_count", cp_cnt, 32'd1);
            check("paddr", PADDR, e.addr);
            check("pwrite", {31'd0, PWRITE}, {31'd0, e.wr});
            if (e.wr) check("pwdata_at_psel", psel_wdata, e.wdata);
            if (e.chk_rdata) check("hrdata", HRDATA, e.rdata);
            if (e.resp) begin
              check("err1_hresp", {31'd0, prev_resp}, 32'd1);
              check("err1_psel", {31'd0, prev_psel}, 32'd0);
            end
            sp_cnt = 0;
            cp_cnt = 0;
          end
        end
        prev_rdy  = HREADYOUT;
        prev_resp = HRESP;
        prev_psel = PSEL;
      end
    end
  end

  // Called at a negedge; presents the address phase, then the write data phase
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic err, input logic stuck,
                       input logic [31:0] rdata, input logic push);
    exp_t e;
    int   n = 0;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr;
    while (!HREADYOUT && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!HREADYOUT) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait: address 0x%08h never accepted within 50 cycles", addr);
    end else begin
      bfm_waits = waits; bfm_err = err; bfm_stuck = stuck; bfm_rdata = rdata;
      e.done_cyc  = cyc + (wr ? 5 : 4) + (stuck ? TO - 1 : waits) + ((err || stuck) ? 1 : 0);
      e.psel_cyc  = cyc + (wr ? 2 : 1);
      e.resp      = err | stuck;
      e.chk_rdata = !wr && !err && !stuck;
      e.rdata     = rdata;
      e.addr      = addr;
      e.wr        = wr;
      e.wdata     = wdata;
      if (push) exp_q.push_back(e);
    end
    @(negedge HCLK);
    HWDATA = wdata; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    @(negedge HCLK);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HADDR = 32'd0; HWDATA = 32'd0;
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_setPenable", {31'd0, setPenable}, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    issue(1'b0, 32'h0000_0010, 32'd0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1);
    wait_done();
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_done();
    issue(1'b0, 32'h0000_0030, 32'd0, 0, 1'b1, 1'b0, 32'hDEAD_0001, 1'b1);
    wait_done();
    // Timeout, then a read taken in ERR2
    issue(1'b0, 32'h0000_0040, 32'd0, 0, 1'b0, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 32'h0000_0044, 32'd0, 0, 1'b0, 1'b0, 32'h55AA_33CC, 1'b1);
    wait_done();
    // Back-to-back read then write, second taken in DONE
    issue(1'b0, 32'h0000_0050, 32'd0, 1, 1'b0, 1'b0, 32'h0BAD_BEEF, 1'b1);
    issue(1'b1, 32'h0000_0060, 32'hA5A5_0F0F, 0, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_done();

    for (int i = 0; i < 4; i++) begin
      HSEL = 1'b1;
      HTRANS = i[0] ? HTRANS_BUSY : HTRANS_IDLE;
      @(negedge HCLK);
      check("idle_busy_psel", {31'd0, PSEL}, 32'd0);
      check("idle_busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("idle_busy_hresp", {31'd0, HRESP}, 32'd0);
    end
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge HCLK);

    // Reset while in ACCESS with PENABLE high
    issue(1'b0, 32'h0000_0070, 32'd0, 0, 1'b0, 1'b1, 32'd0, 1'b0);
    repeat (2) @(negedge HCLK);
    check("pre_reset_penable", {31'd0, PENABLE}, 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("abort_psel", {31'd0, PSEL}, 32'd0);
    check("abort_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("abort_penable", {31'd0, PENABLE}, 32'd0);
    check("abort_hresp", {31'd0, HRESP}, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    issue(1'b0, 32'h0000_0074, 32'd0, 0, 1'b0, 1'b0, 32'h1357_9BDF, 1'b1);
    wait_done();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
